alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequencer between the control unit and the combinational ALU. Accepts one operation at a time over a valid/ready request channel. Registers the operands and opcode and holds them on the ALU inputs for an opcode-dependent number of cycles, so MUL and DIV can be constrained as multicycle paths. Captures the 64-bit ALU result into the Z pair (z_hi/z_lo) and returns it over a valid/ready response channel, flagging illegal opcodes and divide-by-zero.

## Interface
Parameters:
- MUL_CYCLES, 4, cycles operands are held for Mul before capture (≥1)
- DIV_CYCLES, 8, cycles operands are held for Div before capture (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request (high only in IDLE)
- in_opcode  in  5  operation code (shared package constants)
- in_a  in  32  operand A
- in_b  in  32  operand B
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_opcode  out  5  registered opcode to ALU
- alu_result  in  64  ALU result
- out_valid  out  1  response valid
- out_ready  in  1  response accepted
- z_lo  out  32  result low word (quotient for Div)
- z_hi  out  32  result high word (remainder for Div; 0 for 32-bit ops)
- out_err  out  1  illegal opcode or divide-by-zero
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. Any other value is illegal.
- Latency LAT: MUL uses MUL_CYCLES, DIV uses DIV_CYCLES, every other legal op uses 1.
- States and transitions:
  - IDLE: on in_valid&&in_ready, go to EXEC with the counter loaded to LAT-1. If the op is illegal, or it is DIV with in_b==0, go to RESP instead with err=1 and z=0.
  - EXEC: counter==0 → capture and go to RESP; otherwise decrement.
  - RESP: out_valid high. On out_ready, go to IDLE.
- Capture rules:
  - MUL and DIV: {z_hi,z_lo} = alu_result.
  - All other ops: z_lo = alu_result[31:0], z_hi = 0. This holds regardless of alu_result[63:32].
- alu_a, alu_b and alu_opcode are loaded on acceptance. They hold stable through EXEC and RESP and are never changed mid-op.
- z_hi, z_lo and out_err are stable while out_valid is high.
- Request fields are ignored when in_ready is low. There is no acceptance in the cycle a response is consumed.

## Timing
- Reset values: all outputs 0, state IDLE. in_ready becomes 1 the cycle after reset deasserts.
- Acceptance at edge E0:
  - Legal op: capture at edge E0+LAT; out_valid rises after E0+LAT.
  - Illegal op or div-by-zero: out_valid rises after E0+1.
- Response handshake: out_valid high with out_ready sampled high at edge Er → IDLE. in_ready is high after Er.
- Throughput: one op per LAT+2 cycles minimum.
- Backpressure: out_ready low holds RESP indefinitely with outputs unchanged.
- Reset mid-op (EXEC or RESP): the next edge returns to IDLE with all outputs at reset values. No response is produced.
- Counter width is ceil(log2(max(MUL_CYCLES,DIV_CYCLES)))+1 bits; no wrap occurs.

## Structure
- Package alu_ctrl_pkg holds:
  - the opcode localparams listed above (SHRA is distinct from SUB);
  - the state encoding (IDLE, EXEC, RESP);
  - a latency lookup function, opcode → cycles.
- One sub-module, alu_op_decode: combinational opcode → {legal, is_mul, is_div, lat}.
- The ALU is instantiated outside this block.

## Test plan
- ADD a=5, b=7 accepted at E0, out_ready=1 → out_valid after E1; z_lo=12, z_hi=0, err=0.
- MUL a=0x10000, b=0x10000, MUL_CYCLES=4 → alu_* held stable 4 cycles; out_valid after E4; z_hi=1, z_lo=0.
- DIV a=17, b=5 → out_valid after E0+DIV_CYCLES; z_lo=3, z_hi=2. DIV b=0 → out_valid after E1; err=1, z=0.
- Opcode 11111 → err=1, z_hi=z_lo=0 after E1. SHL a=1, b=4 with alu_result[63:32]=garbage → z_lo=16, z_hi=0.
- out_ready low for 5 cycles → out_valid and z held; in_ready=0 throughout; a new in_valid during this time is ignored.
- reset pulsed during MUL EXEC → next cycle: state IDLE, all outputs 0, no out_valid; a following ADD completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU operation sequencer:
//   - opcode_t and the opcode constants understood by the ALU
//   - state_t, the sequencer FSM encoding (IDLE / EXEC / RESP)
//   - op_latency(), the opcode -> hold-cycle lookup
// No ports; imported by the interface, decoder and sequencer top.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int OPCODE_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Cycles the operands must sit on the ALU inputs before the result is
  // captured. Illegal opcodes fall into the single-cycle bucket; the caller
  // decides separately whether the op is legal.
  function automatic logic [31:0] op_latency(input opcode_t op,
                                             input logic [31:0] mul_cycles,
                                             input logic [31:0] div_cycles);
    logic [31:0] lat;
    case (op)
      OP_MUL:  lat = mul_cycles;
      OP_DIV:  lat = div_cycles;
      default: lat = 32'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the request channel, the ALU operand/result bus, the response
// channel and the busy flag of the ALU operation sequencer.
//   slave  : the sequencer side (accepts requests, drives ALU inputs and
//            responses)
//   master : the surrounding environment (control unit issuing requests and
//            consuming responses, plus the ALU returning alu_result)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
  import alu_ctrl_pkg::*;

  logic        in_valid;
  logic        in_ready;
  opcode_t     in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  opcode_t     alu_opcode;
  logic [63:0] alu_result;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        out_err;
  logic        busy;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_opcode, out_valid, z_lo, z_hi,
           out_err, busy
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_opcode, out_valid, z_lo, z_hi,
           out_err, busy
  );

endinterface

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode classification.
// Ports:
//   opcode  in   5      opcode presented on the request channel
//   legal   out  1      opcode is one the ALU implements
//   is_mul  out  1      opcode is MUL
//   is_div  out  1      opcode is DIV
//   lat     out  LAT_W  hold cycles before result capture (>=1)
// ---------------------------------------------------------------------------
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int LAT_W      = 4
) (
  input  opcode_t          opcode,
  output logic             legal,
  output logic             is_mul,
  output logic             is_div,
  output logic [LAT_W-1:0] lat
);

  // Classify the opcode and look up its hold latency.
  always_comb begin
    legal  = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_NEG, OP_NOT: legal = 1'b1;
      OP_MUL: begin
        legal  = 1'b1;
        is_mul = 1'b1;
      end
      OP_DIV: begin
        legal  = 1'b1;
        is_div = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    lat = LAT_W'(op_latency(opcode, 32'(MUL_CYCLES), 32'(DIV_CYCLES)));
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Sits between the control unit and the combinational ALU. Accepts one
// operation at a time, holds operands/opcode on the ALU inputs for an
// opcode-dependent number of cycles (so MUL/DIV can be multicycle paths),
// captures the 64-bit result into z_hi/z_lo and returns it with an error
// flag for illegal opcodes and divide-by-zero.
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   bus    slave    request channel (in_*), ALU bus (alu_*), response
//                   channel (out_*, z_*), busy
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;

  logic             legal_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic [CNT_W-1:0] lat_s;
  logic             reject_s;
  logic             accept_s;
  logic             capture_s;

  logic             in_ready_r;
  logic             busy_r;
  logic             out_valid_r;
  logic [31:0]      alu_a_r;
  logic [31:0]      alu_b_r;
  opcode_t          alu_opcode_r;
  logic             wide_r;
  logic             err_r;
  logic [31:0]      z_lo_r;
  logic [31:0]      z_hi_r;

  alu_op_decode #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .LAT_W      (CNT_W)
  ) u_decode (
    .opcode (bus.in_opcode),
    .legal  (legal_s),
    .is_mul (is_mul_s),
    .is_div (is_div_s),
    .lat    (lat_s)
  );

  assign reject_s = !legal_s || (is_div_s && (bus.in_b == 32'd0));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. Rejected requests still pass through EXEC for one
  // cycle (counter loaded with zero) so they answer with the same timing
  // as any single-cycle op; capture is suppressed for them.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath strobes derived from the current state.
  always_comb begin
    accept_s  = 1'b0;
    capture_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = bus.in_valid && in_ready_r;
    end else if (state_r == ST_EXEC) begin
      capture_s = (cnt_r == CNT_ZERO);
    end else begin
      accept_s  = 1'b0;
      capture_s = 1'b0;
    end
  end

  // Registered outputs, operand hold registers, counter and result capture.
  // Handshake flags are computed from the next state so they line up with
  // the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_opcode_r <= 5'b00000;
      wide_r       <= 1'b0;
      err_r        <= 1'b0;
      z_lo_r       <= 32'd0;
      z_hi_r       <= 32'd0;
      cnt_r        <= CNT_ZERO;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      out_valid_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        alu_a_r      <= bus.in_a;
        alu_b_r      <= bus.in_b;
        alu_opcode_r <= bus.in_opcode;
        wide_r       <= is_mul_s || is_div_s;
        err_r        <= reject_s;
        z_lo_r       <= 32'd0;
        z_hi_r       <= 32'd0;
        cnt_r        <= reject_s ? CNT_ZERO : (lat_s - CNT_ONE);
      end else if (capture_s) begin
        if (!err_r) begin
          z_lo_r <= bus.alu_result[31:0];
          // 32-bit ops never expose the ALU's upper word.
          z_hi_r <= wide_r ? bus.alu_result[63:32] : 32'd0;
        end
      end else if (state_r == ST_EXEC) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_opcode = alu_opcode_r;
  assign bus.z_lo       = z_lo_r;
  assign bus.z_hi       = z_hi_r;
  assign bus.out_err    = err_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. A behavioural ALU drives alu_result
// (with junk in the upper word for 32-bit ops). Each request pushes its
// hand-computed response onto a queue; a monitor pops and compares whenever
// a response handshake occurs.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } resp_t;

  logic  clk = 1'b0;
  logic  reset;
  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [31:0] alu_lo;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MUL_CYCLES (MUL_CYC),
    .DIV_CYCLES (DIV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU; upper word is junk for 32-bit ops.
  always_comb begin
    alu_lo = 32'd0;
    case (bus.alu_opcode)
      OP_ADD:  alu_lo = bus.alu_a + bus.alu_b;
      OP_SUB:  alu_lo = bus.alu_a - bus.alu_b;
      OP_AND:  alu_lo = bus.alu_a & bus.alu_b;
      OP_OR:   alu_lo = bus.alu_a | bus.alu_b;
      OP_SHR:  alu_lo = bus.alu_a >> bus.alu_b[4:0];
      OP_SHRA: alu_lo = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      OP_SHL:  alu_lo = bus.alu_a << bus.alu_b[4:0];
      OP_ROR:  alu_lo = 32'({bus.alu_a, bus.alu_a} >> bus.alu_b[4:0]);
      OP_ROL:  alu_lo = 32'(({bus.alu_a, bus.alu_a} << bus.alu_b[4:0]) >> 32);
      OP_NEG:  alu_lo = 32'd0 - bus.alu_a;
      OP_NOT:  alu_lo = ~bus.alu_a;
      default: alu_lo = 32'h1234_5678;
    endcase
    if (bus.alu_opcode == OP_MUL) begin
      bus.alu_result = 64'(bus.alu_a) * 64'(bus.alu_b);
    end else if (bus.alu_opcode == OP_DIV && bus.alu_b != 32'd0) begin
      bus.alu_result = {bus.alu_a % bus.alu_b, bus.alu_a / bus.alu_b};
    end else begin
      bus.alu_result = {32'hDEAD_BEEF, alu_lo};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),   64'd0);
    check({tag, "_busy"},      64'(bus.busy),       64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid),  64'd0);
    check({tag, "_alu_a"},     64'(bus.alu_a),      64'd0);
    check({tag, "_alu_b"},     64'(bus.alu_b),      64'd0);
    check({tag, "_alu_op"},    64'(bus.alu_opcode), 64'd0);
    check({tag, "_z"},         {bus.z_hi, bus.z_lo}, 64'd0);
    check({tag, "_err"},       64'(bus.out_err),    64'd0);
  endtask

  // Scoreboard monitor: compare every consumed response against the queue.
  always @(negedge clk) begin
    resp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("z_hi", 64'(bus.z_hi), 64'(e.hi));
        check("z_lo", 64'(bus.z_lo), 64'(e.lo));
        check("out_err", 64'(bus.out_err), 64'(e.err));
      end
    end
  end

  // Wait for in_ready, issue one request, push its expected response, then
  // follow it to out_valid checking operand hold and latency.
  task automatic send(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] hi, input logic [31:0] lo, input logic err,
                      input int lat, input logic track = 1'b1);
    int wait_cnt = 0;
    int seen = 0;
    @(negedge clk);
    while (!bus.in_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    if (track) exp_q.push_back('{hi: hi, lo: lo, err: err});
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'hA5A5_A5A5;
    bus.in_b      = 32'h5A5A_5A5A;
    if (track) begin
      while (!bus.out_valid && seen < 100) begin
        check("alu_a_hold", 64'(bus.alu_a), 64'(a));
        check("alu_b_hold", 64'(bus.alu_b), 64'(b));
        check("alu_op_hold", 64'(bus.alu_opcode), 64'(op));
        check("busy_exec", 64'(bus.busy), 64'd1);
        check("in_ready_exec", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        seen++;
      end
      check("latency", 64'(seen), 64'(lat));
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 5'b00000;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    //   op       a             b             z_hi          z_lo          err   lat
    send(OP_ADD,  32'd5,        32'd7,        32'd0,        32'd12,       1'b0, 1);
    send(OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'd1,      32'd0,        1'b0, MUL_CYC);
    send(OP_DIV,  32'd17,       32'd5,        32'd2,        32'd3,        1'b0, DIV_CYC);
    send(OP_DIV,  32'd9,        32'd0,        32'd0,        32'd0,        1'b1, 1);
    send(5'b11111, 32'd3,       32'd4,        32'd0,        32'd0,        1'b1, 1);
    send(OP_SHL,  32'd1,        32'd4,        32'd0,        32'd16,       1'b0, 1);
    send(OP_SUB,  32'd10,       32'd3,        32'd0,        32'd7,        1'b0, 1);
    send(OP_SHRA, 32'h8000_0000, 32'd4,       32'd0,        32'hF800_0000, 1'b0, 1);
    send(OP_SHR,  32'h8000_0000, 32'd4,       32'd0,        32'h0800_0000, 1'b0, 1);
    send(OP_ROR,  32'd1,        32'd1,        32'd0,        32'h8000_0000, 1'b0, 1);
    send(OP_ROL,  32'h8000_0000, 32'd1,       32'd0,        32'd1,        1'b0, 1);
    send(OP_NEG,  32'd1,        32'd0,        32'd0,        32'hFFFF_FFFF, 1'b0, 1);
    send(OP_NOT,  32'h0F0F_0F0F, 32'd0,       32'd0,        32'hF0F0_F0F0, 1'b0, 1);
    send(OP_AND,  32'h0000_00F0, 32'h0000_003C, 32'd0,      32'h0000_0030, 1'b0, 1);
    send(OP_OR,   32'h0000_00F0, 32'h0000_003C, 32'd0,      32'h0000_00FC, 1'b0, 1);
    send(OP_MUL,  32'hFFFF_FFFF, 32'd2,       32'd1,        32'hFFFF_FFFE, 1'b0, MUL_CYC);
    send(5'b00000, 32'd1,       32'd1,        32'd0,        32'd0,        1'b1, 1);
    send(5'b01100, 32'd1,       32'd1,        32'd0,        32'd0,        1'b1, 1);

    // Backpressure: response held, stray request ignored.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd7, 1'b0, 1);
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_SUB;
    bus.in_a      = 32'd100;
    bus.in_b      = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_z", {bus.z_hi, bus.z_lo}, 64'd7);
      check("bp_err", 64'(bus.out_err), 64'd0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_alu_a", 64'(bus.alu_a), 64'd3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset in the middle of a MUL: no response may follow.
    send(OP_MUL, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, MUL_CYC, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midop_reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_no_valid", 64'(bus.out_valid), 64'd0);
    end
    send(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
